fft8_mad_sequencer: RTL

//  Schedules the shared complex multiply-add unit through the 3 radix-2 DIT stages of the 8-point FFT.
//  - Each butterfly is issued as two MAD ops: X=a+W^k*b (twiddle k), Y=a+W^(k+4)*b (W^(k+4) = -W^k).
//  - Drives read addresses to a ping-pong sample buffer, the twiddle index to the MAD unit, and delayed

---
 rtl/fft8_pkg.sv | 17 +
 rtl/fft8_addr_gen.sv | 49 ++++
 rtl/fft8_mad_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// Shared constants, state encoding and bit-reversal helper for the 8-point FFT sequencer.
package fft8_pkg;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int TW_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2]};
  endfunction
endpackage

// File: rtl/fft8_addr_gen.sv
// Combinational butterfly addressing: (stage, op) -> operand addresses, twiddle index, result address.
import fft8_pkg::*;

module fft8_addr_gen #(
  parameter bit BITREV_IN = 1'b1
) (
  input  logic [1:0]       stage,
  input  logic [2:0]       op,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [TW_W-1:0]  twiddle_index,
  output logic [LOG2N-1:0] wr_addr
);
  logic [1:0]       j;
  logic [1:0]       k;
  logic [LOG2N-1:0] top;
  logic [LOG2N-1:0] bot;
  logic             rev;

  always_comb begin
    j   = op[2:1];
    top = '0;
    bot = '0;
    k   = '0;
    // top/bot differ only in the bit at position s; the butterfly index fills the rest
    case (stage)
      2'd0: begin
        top = {j, 1'b0};
        bot = {j, 1'b1};
        k   = 2'd0;
      end
      2'd1: begin
        top = {j[1], 1'b0, j[0]};
        bot = {j[1], 1'b1, j[0]};
        k   = {j[0], 1'b0};
      end
      default: begin
        top = {1'b0, j};
        bot = {1'b1, j};
        k   = j;
      end
    endcase
    rev           = BITREV_IN && (stage == 2'd0);
    rd_addr_a     = rev ? bitrev3(top) : top;
    rd_addr_b     = rev ? bitrev3(bot) : bot;
    twiddle_index = {op[0], k};
    wr_addr       = op[0] ? bot : top;
  end
endmodule

// File: rtl/fft8_mad_sequencer.sv
// Issues the 24 MAD operations of an 8-point radix-2 DIT FFT and delays write-back to match MAD latency.
import fft8_pkg::*;

module fft8_mad_sequencer #(
  parameter int MAD_LATENCY = 6,
  parameter int RD_LATENCY  = 1,
  parameter bit BITREV_IN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                rd_en,
  output logic                rd_bank,
  output logic [LOG2N-1:0]    rd_addr_a,
  output logic [LOG2N-1:0]    rd_addr_b,
  output logic [TW_W-1:0]     twiddle_index,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [LOG2N-1:0]    wr_addr,
  output logic [1:0]          stage,
  output logic                busy,
  output logic                done
);
  localparam int L = RD_LATENCY + MAD_LATENCY;

  state_e     state;
  logic [1:0] stage_q;
  logic [2:0] op_q;
  logic [7:0] drain_cnt;

  logic [LOG2N-1:0] addr_a_c;
  logic [LOG2N-1:0] addr_b_c;
  logic [TW_W-1:0]  tw_c;
  logic [LOG2N-1:0] wr_addr_c;

  logic [L-1:0]     wb_vld_p;
  logic [LOG2N-1:0] wb_addr_p [L];
  logic             wb_bank_p [L];

  fft8_addr_gen #(.BITREV_IN(BITREV_IN)) u_addr_gen (
    .stage         (stage_q),
    .op            (op_q),
    .rd_addr_a     (addr_a_c),
    .rd_addr_b     (addr_b_c),
    .twiddle_index (tw_c),
    .wr_addr       (wr_addr_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stage_q   <= '0;
      op_q      <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= ISSUE;
            stage_q <= '0;
            op_q    <= '0;
          end
        end
        ISSUE: begin
          if (abort) begin
            state   <= IDLE;
            stage_q <= '0;
            op_q    <= '0;
          end else if (op_q == 3'(N-1)) begin
            state     <= DRAIN;
            op_q      <= '0;
            drain_cnt <= '0;
          end else begin
            op_q <= op_q + 3'd1;
          end
        end
        DRAIN: begin
          if (abort) begin
            state   <= IDLE;
            stage_q <= '0;
          end else if (drain_cnt == 8'(L-1)) begin
            if (stage_q == 2'(LOG2N-1)) begin
              state <= DONE;
            end else begin
              state   <= ISSUE;
              stage_q <= stage_q + 2'd1;
            end
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          stage_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line: valid is flushed on reset/abort, payload rides along unreset
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wb_vld_p <= '0;
    end else begin
      wb_vld_p <= {wb_vld_p[L-2:0], rd_en};
    end
  end

  always_ff @(posedge clk) begin
    wb_addr_p[0] <= wr_addr_c;
    wb_bank_p[0] <= ~stage_q[0];
    for (int i = 1; i < L; i++) begin
      wb_addr_p[i] <= wb_addr_p[i-1];
      wb_bank_p[i] <= wb_bank_p[i-1];
    end
  end

  always_comb begin
    rd_en         = (state == ISSUE);
    rd_bank       = stage_q[0];
    rd_addr_a     = rd_en ? addr_a_c : '0;
    rd_addr_b     = rd_en ? addr_b_c : '0;
    twiddle_index = rd_en ? tw_c : '0;
    wr_en         = wb_vld_p[L-1];
    wr_addr       = wr_en ? wb_addr_p[L-1] : '0;
    wr_bank       = wr_en & wb_bank_p[L-1];
    stage         = stage_q;
    busy          = (state != IDLE);
    done          = (state == DONE);
  end
endmodule
